q_table_update_v3: RTL and testbench

Q_TABLE_UPDATE_V3 -- requirements
Module: q_table_update_v3

---
 rtl/q_table_pkg.sv | 27 ++
 rtl/q_table_bank.sv | 28 ++
 rtl/q_table_update_v3.sv | 228 ++++++++++++++++++++++
 tb/tb_q_table_update_v3.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/q_table_pkg.sv
// Shared types and constants for the Q-table update engine and its storage banks.
// QTABLE_KNOWN_CH_EN adds the known-cluster-head states to the FSM encoding.
package q_table_pkg;

    localparam int DEFAULT_WORD_WIDTH = 16;

    // Received packet types; only PKT_NONE changes the engine's behaviour.
    localparam logic [2:0] PKT_NONE  = 3'b000;
    localparam logic [2:0] PKT_HELLO = 3'b001;
    localparam logic [2:0] PKT_JOIN  = 3'b010;
    localparam logic [2:0] PKT_DATA  = 3'b011;
    localparam logic [2:0] PKT_ADV   = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        NB_RD  = 3'd1,
        NB_CMP = 3'd2,
        NB_WR  = 3'd3,
`ifdef QTABLE_KNOWN_CH_EN
        CH_RD  = 3'd4,
        CH_CMP = 3'd5,
        CH_WR  = 3'd6,
`endif
        DONE   = 3'd7
    } qt_state_e;

endpackage

// File: rtl/q_table_bank.sv
// Single-port storage bank: synchronous write, registered read (1-cycle latency).
// Instances hold the neighbor ID, cluster, energy, Q and known-CH columns.
module q_table_bank
    import q_table_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic [DATA_WIDTH-1:0] rdData
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose -- contents are only meaningful
    // below the stored entry count, and a reset would stop it mapping to RAM.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[addr] <= wrData;
        end
        rdData <= mem[addr];
    end

endmodule

// File: rtl/q_table_update_v3.sv
// Q-table update engine: looks up the packet's source in the neighbor bank, then
// overwrites or appends it. Define QTABLE_KNOWN_CH_EN to add known-CH tracking.
module q_table_update_v3
    import q_table_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int MAX_NEIGHBORS = 16,
    parameter int MAX_CH        = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] fSourceID,
    input  logic [WORD_WIDTH-1:0] fSourceHops,
    input  logic [WORD_WIDTH-1:0] fClusterID,
    input  logic [WORD_WIDTH-1:0] fEnergyLeft,
    input  logic [WORD_WIDTH-1:0] fQValue,
    input  logic [WORD_WIDTH-1:0] fKnownCH,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mClusterID,
    input  logic [WORD_WIDTH-1:0] mEnergyLeft,
    input  logic [WORD_WIDTH-1:0] mQValue,
    input  logic [WORD_WIDTH-1:0] mKnownCH,
    input  logic [WORD_WIDTH-1:0] mNeighborCount,
    input  logic [WORD_WIDTH-1:0] mKnownCHCount,
    output logic [WORD_WIDTH-1:0] nodeID,
    output logic [WORD_WIDTH-1:0] nodeHops,
    output logic [WORD_WIDTH-1:0] nodeClusterID,
    output logic [WORD_WIDTH-1:0] nodeEnergy,
    output logic [WORD_WIDTH-1:0] nodeQValue,
    output logic [WORD_WIDTH-1:0] neighborCount,
    output logic [WORD_WIDTH-1:0] knownCH,
    output logic [WORD_WIDTH-1:0] knownCHCount,
    output logic                  wr_en,
    output logic                  wr_en_ch,
    output logic                  done
);

    localparam logic [WORD_WIDTH-1:0] ONE      = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] NB_LIMIT = WORD_WIDTH'(MAX_NEIGHBORS);

    qt_state_e             state;
    logic [WORD_WIDTH-1:0] nbBase;     // neighbor count captured at start
    logic                  nbAppend;
    logic [WORD_WIDTH-1:0] nbFinal;
    logic                  startScan;
    logic                  nbMatch;
    logic                  nbLast;
    logic                  nbWriteStart;
    logic                  unusedInputs;

`ifdef QTABLE_KNOWN_CH_EN
    localparam logic [WORD_WIDTH-1:0] CH_LIMIT = WORD_WIDTH'(MAX_CH);

    logic [WORD_WIDTH-1:0] chBase;
    logic                  chAppend;
    logic [WORD_WIDTH-1:0] chFinal;
    logic                  chMatch;
    logic                  chLast;
    logic                  chWriteStart;
`endif

    // NOTE: every signal here is assigned on every pass through the block, so
    // no path leaves a value unassigned and no latch can be inferred.
    always_comb begin
        startScan    = (state == IDLE) && en && (fPacketType != PKT_NONE);
        nbMatch      = (state == NB_CMP) && (mSourceID == fSourceID);
        nbLast       = (state == NB_CMP) && (neighborCount == nbBase - ONE);
        // Overwrite on a hit; append when an empty table or a full miss leaves room.
        nbWriteStart = nbMatch
                     || (startScan && (mNeighborCount == '0))
                     || (nbLast && !nbMatch && (nbBase < NB_LIMIT));
        nbFinal      = nbAppend ? nbBase + ONE : nbBase;
`ifdef QTABLE_KNOWN_CH_EN
        chMatch      = (state == CH_CMP) && (mKnownCH == fKnownCH);
        chLast       = (state == CH_CMP) && (knownCHCount == chBase - ONE);
        chWriteStart = ((state == NB_WR) && (fKnownCH != '0) && (chBase == '0)
                        && (CH_LIMIT != '0))
                     || (chLast && !chMatch && (chBase < CH_LIMIT));
        chFinal      = chAppend ? chBase + ONE : chBase;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register below sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state         <= IDLE;
            nbBase        <= '0;
            nbAppend      <= 1'b0;
            nodeID        <= '0;
            nodeHops      <= '0;
            nodeClusterID <= '0;
            nodeEnergy    <= '0;
            nodeQValue    <= '0;
            neighborCount <= '0;
            wr_en         <= 1'b0;
            done          <= 1'b0;
`ifdef QTABLE_KNOWN_CH_EN
            chBase        <= '0;
            chAppend      <= 1'b0;
            knownCH       <= '0;
            knownCHCount  <= '0;
            wr_en_ch      <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
`ifdef QTABLE_KNOWN_CH_EN
            wr_en_ch <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (en) begin
                        nbBase   <= mNeighborCount;
                        nbAppend <= 1'b0;
`ifdef QTABLE_KNOWN_CH_EN
                        chBase   <= mKnownCHCount;
                        chAppend <= 1'b0;
`endif
                        if (fPacketType == PKT_NONE) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            neighborCount <= mNeighborCount;
`ifdef QTABLE_KNOWN_CH_EN
                            knownCHCount  <= mKnownCHCount;
`endif
                        end else if (mNeighborCount == '0) begin
                            state <= NB_WR;
                        end else begin
                            state         <= NB_RD;
                            neighborCount <= '0;
                        end
                    end
                end

                NB_RD: state <= NB_CMP;

                NB_CMP: begin
                    if (nbMatch || nbLast) begin
                        state <= NB_WR;
                    end else begin
                        state         <= NB_RD;
                        neighborCount <= neighborCount + ONE;
                    end
                end

                NB_WR: begin
`ifdef QTABLE_KNOWN_CH_EN
                    if (fKnownCH == '0) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        neighborCount <= nbFinal;
                        knownCHCount  <= chFinal;
                    end else if (chBase == '0) begin
                        state <= CH_WR;
                    end else begin
                        state        <= CH_RD;
                        knownCHCount <= '0;
                    end
`else
                    state         <= DONE;
                    done          <= 1'b1;
                    neighborCount <= nbFinal;
`endif
                end

`ifdef QTABLE_KNOWN_CH_EN
                CH_RD: state <= CH_CMP;

                CH_CMP: begin
                    if (chMatch || chLast) begin
                        state <= CH_WR;
                    end else begin
                        state        <= CH_RD;
                        knownCHCount <= knownCHCount + ONE;
                    end
                end

                CH_WR: begin
                    state         <= DONE;
                    done          <= 1'b1;
                    neighborCount <= nbFinal;
                    knownCHCount  <= chFinal;
                end
`endif

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Write data is loaded on the edge that enters the write state.
            if (nbWriteStart) begin
                wr_en         <= 1'b1;
                nodeID        <= fSourceID;
                nodeHops      <= fSourceHops;
                nodeClusterID <= fClusterID;
                nodeEnergy    <= fEnergyLeft;
                nodeQValue    <= fQValue;
                if (!nbMatch) begin
                    neighborCount <= startScan ? mNeighborCount : nbBase;
                    nbAppend      <= 1'b1;
                end
            end
`ifdef QTABLE_KNOWN_CH_EN
            if (chWriteStart) begin
                wr_en_ch     <= 1'b1;
                knownCH      <= fKnownCH;
                knownCHCount <= chBase;
                chAppend     <= 1'b1;
            end
`endif
        end
    end

    // Stored cluster/energy/Q columns are written here but never compared.
`ifdef QTABLE_KNOWN_CH_EN
    assign unusedInputs = ^{mClusterID, mEnergyLeft, mQValue};
`else
    assign wr_en_ch     = 1'b0;
    assign knownCH      = '0;
    assign knownCHCount = '0;
    assign unusedInputs = ^{fKnownCH, mKnownCH, mKnownCHCount,
                            mClusterID, mEnergyLeft, mQValue};
`endif

endmodule

// File: tb/tb_q_table_update_v3.sv
// Directed bench for q_table_update_v3 backed by q_table_bank storage.
// Build with QTABLE_KNOWN_CH_EN defined to exercise known-CH tracking.
`timescale 1ns/1ps
module tb_q_table_update_v3;
    import q_table_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         nrst;
    logic         en;
    logic [W-1:0] fSourceID, fSourceHops, fClusterID, fEnergyLeft, fQValue, fKnownCH;
    logic [2:0]   fPacketType;
    logic [W-1:0] mSourceID, mClusterID, mEnergyLeft, mQValue, mKnownCH;
    logic [W-1:0] nbCnt, chCnt;
    logic [W-1:0] nodeID, nodeHops, nodeClusterID, nodeEnergy, nodeQValue;
    logic [W-1:0] neighborCount, knownCH, knownCHCount;
    logic         wr_en, wr_en_ch, done;

    int assertions = 0;
    int failures   = 0;

    // Per-operation observations
    int           lat, wrCycles, wrAt, chCycles, doneCycles, seen;
    logic [W-1:0] wrIdx, wrId, wrHops, wrCl, wrEnergy, wrQ, chIdx, chVal, endNb, endCh;

    always #5 clk = ~clk;

    q_table_update_v3 #(.WORD_WIDTH(W), .MAX_NEIGHBORS(16), .MAX_CH(8)) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .fSourceID(fSourceID), .fSourceHops(fSourceHops), .fClusterID(fClusterID),
        .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fKnownCH(fKnownCH),
        .fPacketType(fPacketType),
        .mSourceID(mSourceID), .mClusterID(mClusterID), .mEnergyLeft(mEnergyLeft),
        .mQValue(mQValue), .mKnownCH(mKnownCH),
        .mNeighborCount(nbCnt), .mKnownCHCount(chCnt),
        .nodeID(nodeID), .nodeHops(nodeHops), .nodeClusterID(nodeClusterID),
        .nodeEnergy(nodeEnergy), .nodeQValue(nodeQValue),
        .neighborCount(neighborCount), .knownCH(knownCH), .knownCHCount(knownCHCount),
        .wr_en(wr_en), .wr_en_ch(wr_en_ch), .done(done)
    );

    q_table_bank #(.DATA_WIDTH(W), .DEPTH(16), .ADDR_WIDTH(4)) idBank (
        .clk(clk), .wrEn(wr_en), .addr(neighborCount[3:0]), .wrData(nodeID), .rdData(mSourceID));
    q_table_bank #(.DATA_WIDTH(W), .DEPTH(16), .ADDR_WIDTH(4)) clBank (
        .clk(clk), .wrEn(wr_en), .addr(neighborCount[3:0]), .wrData(nodeClusterID), .rdData(mClusterID));
    q_table_bank #(.DATA_WIDTH(W), .DEPTH(16), .ADDR_WIDTH(4)) enBank (
        .clk(clk), .wrEn(wr_en), .addr(neighborCount[3:0]), .wrData(nodeEnergy), .rdData(mEnergyLeft));
    q_table_bank #(.DATA_WIDTH(W), .DEPTH(16), .ADDR_WIDTH(4)) qBank (
        .clk(clk), .wrEn(wr_en), .addr(neighborCount[3:0]), .wrData(nodeQValue), .rdData(mQValue));
    q_table_bank #(.DATA_WIDTH(W), .DEPTH(8), .ADDR_WIDTH(3)) chBank (
        .clk(clk), .wrEn(wr_en_ch), .addr(knownCHCount[2:0]), .wrData(knownCH), .rdData(mKnownCH));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse en for one cycle, then watch until two cycles past done (bounded).
    // reEnAt > 0 re-pulses en at that cycle to show it is ignored mid-run.
    task automatic runOp(input logic [W-1:0] id, input logic [W-1:0] hops,
                         input logic [W-1:0] cl, input logic [W-1:0] energy,
                         input logic [W-1:0] q, input logic [W-1:0] ch,
                         input logic [2:0] typ, input int reEnAt);
        fSourceID = id; fSourceHops = hops; fClusterID = cl;
        fEnergyLeft = energy; fQValue = q; fKnownCH = ch; fPacketType = typ;
        lat = 0; wrCycles = 0; wrAt = 0; chCycles = 0; doneCycles = 0;
        @(negedge clk);
        en = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            en = 1'b0;
            if (wr_en) begin
                wrCycles++; wrAt = c; wrIdx = neighborCount; wrId = nodeID;
                wrHops = nodeHops; wrCl = nodeClusterID; wrEnergy = nodeEnergy; wrQ = nodeQValue;
            end
            if (wr_en_ch) begin
                chCycles++; chIdx = knownCHCount; chVal = knownCH;
            end
            if (done) begin
                doneCycles++;
                if (lat == 0) begin
                    lat = c; endNb = neighborCount; endCh = knownCHCount;
                end
            end
            if (lat != 0 && c >= lat + 2) break;
            if (c == reEnAt) en = 1'b1;
        end
    endtask

    initial begin
        nrst = 1'b1; en = 1'b0;
        fSourceID = '0; fSourceHops = '0; fClusterID = '0; fEnergyLeft = '0;
        fQValue = '0; fKnownCH = '0; fPacketType = 3'b000;
        nbCnt = '0; chCnt = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_en_ch", 32'(wr_en_ch), 0);
        check("rst_done", 32'(done), 0);
        check("rst_neighborCount", 32'(neighborCount), 0);
        check("rst_nodeID", 32'(nodeID), 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        nrst = 1'b0;

        // Reset in the middle of a scan over three entries
        nbCnt = 16'd3;
        fSourceID = 16'd5; fPacketType = 3'b001;
        @(negedge clk); en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        #1;
        check("midrst_state", 32'(dut.state), 32'(IDLE));
        check("midrst_neighborCount", 32'(neighborCount), 0);
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_done", 32'(done), 0);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) nrst = 1'b0;
            if (done || wr_en) seen++;
        end
        check("midrst_no_pulse", 32'(seen), 0);

        // First append into an empty table
        nbCnt = 16'd0;
        runOp(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd0, 3'b101, 0);
        check("app1_latency", 32'(lat), 2);
        check("app1_wr_cycles", 32'(wrCycles), 1);
        check("app1_wr_before_done", 32'(wrAt), 1);
        check("app1_index", 32'(wrIdx), 0);
        check("app1_nodeID", 32'(wrId), 32'h1);
        check("app1_nodeHops", 32'(wrHops), 32'h2);
        check("app1_nodeClusterID", 32'(wrCl), 32'h2);
        check("app1_nodeEnergy", 32'(wrEnergy), 32'h8000);
        check("app1_nodeQValue", 32'(wrQ), 32'h3000);
        check("app1_done_cycles", 32'(doneCycles), 1);
        check("app1_count", 32'(endNb), 1);
        check("app1_ch_count", 32'(endCh), 0);
        nbCnt = 16'd1;

        // Second append after a one-entry miss
        runOp(16'd17, 16'd3, 16'd2, 16'h1800, 16'hB800, 16'd0, 3'b101, 0);
        check("app2_latency", 32'(lat), 4);
        check("app2_wr_cycles", 32'(wrCycles), 1);
        check("app2_wr_before_done", 32'(wrAt), 3);
        check("app2_index", 32'(wrIdx), 1);
        check("app2_nodeEnergy", 32'(wrEnergy), 32'h1800);
        check("app2_nodeQValue", 32'(wrQ), 32'hB800);
        check("app2_count", 32'(endNb), 2);
        nbCnt = 16'd2;

        // Update of the first entry
        runOp(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3800, 16'd0, 3'b101, 0);
        check("upd0_latency", 32'(lat), 4);
        check("upd0_wr_cycles", 32'(wrCycles), 1);
        check("upd0_index", 32'(wrIdx), 0);
        check("upd0_nodeQValue", 32'(wrQ), 32'h3800);
        check("upd0_count", 32'(endNb), 2);

        // Update of the last entry
        runOp(16'd17, 16'd3, 16'd2, 16'h1800, 16'h1234, 16'd0, 3'b101, 0);
        check("upd1_latency", 32'(lat), 6);
        check("upd1_index", 32'(wrIdx), 1);
        check("upd1_count", 32'(endNb), 2);

        // Fill the table to its 16-entry limit
        for (int k = 2; k < 16; k++) begin
            runOp(16'(100 + k), 16'd1, 16'd3, 16'h4000, 16'h0800, 16'd0, 3'b011, 0);
            check($sformatf("fill%0d_index", k), 32'(wrIdx), 32'(k));
            check($sformatf("fill%0d_count", k), 32'(endNb), 32'(k + 1));
            nbCnt = 16'(k + 1);
        end
        check("fill_last_latency", 32'(lat), 32);

        // Full table, new ID: no write, count unchanged; mid-run en ignored
        runOp(16'd99, 16'd1, 16'd1, 16'h1000, 16'h1000, 16'd0, 3'b101, 10);
        check("full_latency", 32'(lat), 34);
        check("full_wr_cycles", 32'(wrCycles), 0);
        check("full_done_cycles", 32'(doneCycles), 1);
        check("full_count", 32'(endNb), 16);

        // Packet type 000: straight to done, no writes
        runOp(16'd5, 16'd1, 16'd1, 16'h1000, 16'h1000, 16'd0, 3'b000, 0);
        check("ign_latency", 32'(lat), 1);
        check("ign_wr_cycles", 32'(wrCycles), 0);
        check("ign_done_cycles", 32'(doneCycles), 1);
        check("ign_count", 32'(endNb), 16);
        check("hold_neighborCount", 32'(neighborCount), 16);
        check("hold_nodeID", 32'(nodeID), 115);

        // Known-CH tracking on a matching neighbor
        runOp(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3800, 16'd15, 3'b101, 0);
        check("ch_nb_index", 32'(wrIdx), 0);
        check("ch_nb_count", 32'(endNb), 16);
`ifdef QTABLE_KNOWN_CH_EN
        check("ch_latency", 32'(lat), 5);
        check("ch_wr_cycles", 32'(chCycles), 1);
        check("ch_index", 32'(chIdx), 0);
        check("ch_knownCH", 32'(chVal), 15);
        check("ch_count", 32'(endCh), 1);
        chCnt = 16'd1;
        runOp(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3800, 16'd15, 3'b101, 0);
        check("ch_dup_latency", 32'(lat), 7);
        check("ch_dup_wr_cycles", 32'(chCycles), 0);
        check("ch_dup_count", 32'(endCh), 1);
`else
        check("ch_off_latency", 32'(lat), 4);
        check("ch_off_wr_cycles", 32'(chCycles), 0);
        check("ch_off_count", 32'(endCh), 0);
        check("ch_off_knownCH", 32'(knownCH), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
